// File: rtl/bin2bcd_if.sv
// Handshake bundle between an operand producer/result consumer and bin2bcd_seq.
interface bin2bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [2:0]            ndigits;
    logic                  ovf;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, ndigits, ovf
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, ndigits, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready on both sides.
// One conversion in flight; DONE can accept the next operand on the consuming edge.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic       clk,
    input  logic       rst,
    bin2bcd_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
    logic                ovf_q, ovf_d;
    logic                capture;
    logic [2:0]          nd;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bin_d         = bin_q;
        bcd_d         = bcd_q;
        ovf_d         = ovf_q;
        capture       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                capture      = bus.in_valid;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                // A set MSB in the adjusted top digit would be shifted out of range.
                ovf_d = ovf_q | bcd_adj[4*DIGITS-1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    capture = bus.in_valid;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            bin_d   = bus.bin_in;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = SHIFT;
        end
    end

    always_comb begin
        nd = 3'd1;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                nd = 3'(i + 1);
            end
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.ndigits = nd;
    assign bus.ovf     = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default 5-digit build plus a 3-digit build for overflow.
module tb_bin2bcd_seq;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bin2bcd_if #(.WIDTH(16), .DIGITS(5)) bus  ();
    bin2bcd_if #(.WIDTH(16), .DIGITS(3)) bus3 ();

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] refBcd(int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int refNd(int unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    // Present one operand from IDLE; returns on the negedge just after the capturing edge.
    task automatic applyStimulus(input logic [15:0] value);
        bus.bin_in   = value;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("in_ready_drop", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("consume_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("consume_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic convertAndCheck(input string tag, input logic [15:0] value,
                                   input logic [19:0] expBcd, input int expNd);
        int cyc;
        applyStimulus(value);
        waitDone(cyc);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd16);
        checkOutput({tag, "_bcd"}, 32'(bus.bcd_out), 32'(expBcd));
        checkOutput({tag, "_nd"}, 32'(bus.ndigits), 32'(expNd));
        checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        consume();
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [15:0] rv;
        errors = 0;
        checks = 0;
        bus.in_valid   = 1'b0;
        bus.bin_in     = '0;
        bus.out_ready  = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.bin_in    = '0;
        bus3.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_bcd", 32'(bus.bcd_out), 32'd0);
        checkOutput("reset_nd", 32'(bus.ndigits), 32'd1);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);

        convertAndCheck("zero", 16'd0, 20'h00000, 1);
        convertAndCheck("max_prod", 16'd65025, 20'h65025, 5);
        convertAndCheck("all_ones", 16'd65535, 20'h65535, 5);
        convertAndCheck("nine", 16'd9, 20'h00009, 1);
        convertAndCheck("hundred", 16'd100, 20'h00100, 3);
        convertAndCheck("v40960", 16'd40960, 20'h40960, 5);

        // Backpressure: result must hold while the producer keeps poking in_valid.
        applyStimulus(16'd4321);
        waitDone(cyc);
        checkOutput("bp_latency", 32'(cyc), 32'd16);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'(i % 2);
            bus.bin_in   = 16'($urandom_range(0, 65535));
            @(negedge clk);
            checkOutput("bp_bcd", 32'(bus.bcd_out), 32'h04321);
            checkOutput("bp_nd", 32'(bus.ndigits), 32'd4);
            checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        consume();
        checkOutput("bp_no_capture", 32'(bus.bcd_out), 32'h04321);

        // Back-to-back: consume and capture on the same edge.
        applyStimulus(16'd777);
        waitDone(cyc);
        checkOutput("b2b_first_bcd", 32'(bus.bcd_out), 32'h00777);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bin_in    = 16'd1234;
        #1;
        checkOutput("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
        waitDone(cyc);
        checkOutput("b2b_latency", 32'(cyc), 32'd16);
        checkOutput("b2b_bcd", 32'(bus.bcd_out), 32'h01234);
        checkOutput("b2b_nd", 32'(bus.ndigits), 32'd4);
        consume();

        // Reset in the middle of a conversion discards it.
        applyStimulus(16'd4242);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_bcd", 32'(bus.bcd_out), 32'd0);
        checkOutput("mid_rst_nd", 32'(bus.ndigits), 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) pulses++;
        end
        checkOutput("mid_rst_no_pulse", 32'(pulses), 32'd0);
        convertAndCheck("after_rst", 16'd500, 20'h00500, 3);

        // Reduced-digit build: overflow detection and its clearing on the next capture.
        bus3.bin_in   = 16'd1000;
        bus3.in_valid = 1'b1;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        repeat (16) @(negedge clk);
        checkOutput("d3_valid", 32'(bus3.out_valid), 32'd1);
        checkOutput("d3_ovf_1000", 32'(bus3.ovf), 32'd1);
        bus3.bin_in    = 16'd999;
        bus3.in_valid  = 1'b1;
        bus3.out_ready = 1'b1;
        @(negedge clk);
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 1'b0;
        checkOutput("d3_ovf_cleared", 32'(bus3.ovf), 32'd0);
        repeat (16) @(negedge clk);
        checkOutput("d3_valid_999", 32'(bus3.out_valid), 32'd1);
        checkOutput("d3_ovf_999", 32'(bus3.ovf), 32'd0);
        checkOutput("d3_bcd_999", 32'(bus3.bcd_out), 32'h999);
        checkOutput("d3_nd_999", 32'(bus3.ndigits), 32'd3);

        for (int i = 0; i < 1000; i++) begin
            rv = 16'($urandom_range(0, 65535));
            convertAndCheck("rand", rv, refBcd(32'(rv)), refNd(32'(rv)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
